// File: rtl/interp_tap_sum.sv
// Signs, sums, rounds, shifts and clips four interpolation tap products into one sample.
// Two-stage pipeline with 2-cycle latency; each stage loads when it is empty or the next stage drains.
module interp_tap_sum #(
  parameter int          DATA_W   = 32,
  parameter int          OUT_W    = 10,
  parameter int          SHIFT    = 6,
  parameter logic [3:0]  NEG_TAPS = 4'b1001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_frac,
  input  logic signed [DATA_W-1:0] in_p0,
  input  logic signed [DATA_W-1:0] in_p1,
  input  logic signed [DATA_W-1:0] in_p2,
  input  logic signed [DATA_W-1:0] in_p3,
  input  logic signed [DATA_W-1:0] in_center,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data
);

  // Two guard bits keep the four-term sum of full-scale products from wrapping.
  localparam int SW = DATA_W + 2;
  localparam logic signed [SW-1:0] RND  = SW'(64'(1) << (SHIFT - 1));
  localparam logic signed [SW-1:0] MAXV = SW'((64'(1) << OUT_W) - 64'(1));

  function automatic logic signed [SW-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{2{x[DATA_W-1]}}, x};
  endfunction

  function automatic logic signed [SW-1:0] sgn(input logic signed [DATA_W-1:0] x,
                                               input logic neg);
    logic signed [SW-1:0] e;
    e = sext(x);
    return neg ? -e : e;
  endfunction

  logic                     v1, v2;
  logic                     en1, en2;
  logic signed [SW-1:0]     s01, s23;
  logic                     byp1;
  logic signed [DATA_W-1:0] c1;

  logic signed [SW-1:0]     acc;
  logic signed [SW-1:0]     r;
  logic [OUT_W-1:0]         clip;

  assign en2       = !v2 || out_ready;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      s01  <= '0;
      s23  <= '0;
      byp1 <= 1'b0;
      c1   <= '0;
    end else if (en1) begin
      v1   <= in_valid;
      s01  <= sgn(in_p0, NEG_TAPS[0]) + sgn(in_p1, NEG_TAPS[1]);
      s23  <= sgn(in_p2, NEG_TAPS[2]) + sgn(in_p3, NEG_TAPS[3]);
      byp1 <= (in_frac == 4'd0);
      c1   <= in_center;
    end
  end

  // Full-pel beats skip rounding and normalisation but still pass the clip.
  always_comb begin
    acc  = s01 + s23 + RND;
    r    = byp1 ? sext(c1) : (acc >>> SHIFT);
    clip = '0;
    if (r < 0)
      clip = '0;
    else if (r > MAXV)
      clip = MAXV[OUT_W-1:0];
    else
      clip = r[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      out_data <= '0;
    end else if (en2) begin
      v2       <= v1;
      out_data <= clip;
    end
  end

endmodule

// File: tb/tb_interp_tap_sum.sv
// Directed checks for interp_tap_sum: arithmetic, clipping, bypass, flow control and reset.
module tb_interp_tap_sum;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_frac;
  logic signed [31:0] in_p0, in_p1, in_p2, in_p3, in_center;
  logic               out_valid;
  logic               out_ready;
  logic [9:0]         out_data;

  int chk_cnt;
  int pass_cnt;

  interp_tap_sum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_frac   (in_frac),
    .in_p0     (in_p0),
    .in_p1     (in_p1),
    .in_p2     (in_p2),
    .in_p3     (in_p3),
    .in_center (in_center),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_beat(input logic [3:0] f, input int a, input int b, input int c,
                          input int d, input int ctr);
    in_frac   = f;
    in_p0     = a;
    in_p1     = b;
    in_p2     = c;
    in_p3     = d;
    in_center = ctr;
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 10'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  // One beat through an empty pipeline with out_ready high; checks latency and value.
  task automatic run_one(input string name, input logic [3:0] f, input int a, input int b,
                         input int c, input int d, input int ctr, input int expv);
    @(negedge clk);
    out_ready = 1'b1;
    set_beat(f, a, b, c, d, ctr);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL %s_early_valid: got %b expected 0", name, out_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 10'(expv))
      $display("FAIL %s: got valid=%b data=%0d expected valid=1 data=%0d",
               name, out_valid, out_data, expv);
    else pass_cnt++;
  endtask

  task automatic test_filter();
    run_one("unity",      4'd8, 0,     6400,   0,   0, 0, 100);
    run_one("neg_clip",   4'd8, 10000, 0,      0,   0, 0, 0);
    run_one("high_clip",  4'd8, 0,     128000, 0,   0, 0, 1023);
    run_one("round_32",   4'd5, 0,     32,     0,   0, 0, 1);
    run_one("round_31",   4'd5, 0,     31,     0,   0, 0, 0);
    run_one("round_96_32",4'd5, 32,    96,     0,   0, 0, 1);
    run_one("round_m31",  4'd5, 0,     0,      -31, 0, 0, 0);
    run_one("neg_tap3",   4'd3, 0,     640,    0,   320, 0, 5);
  endtask

  task automatic test_bypass();
    run_one("byp_512",  4'd0, 9999, 9999, 9999, 9999, 512,  512);
    run_one("byp_neg",  4'd0, 9999, 9999, 9999, 9999, -5,   0);
    run_one("byp_high", 4'd0, 9999, 9999, 9999, 9999, 4000, 1023);
  endtask

  // Mixed bypass/filtered beats every cycle with the consumer always ready.
  task automatic test_back_to_back();
    logic [3:0] fq [6] = '{4'd0, 4'd8, 4'd0, 4'd8, 4'd2, 4'd0};
    int         p1q[6] = '{0, 6400, 0, 10000, 3200, 0};
    int         p0q[6] = '{0, 0, 0, 0, 0, 0};
    int         cq [6] = '{512, 0, 4000, 0, 0, 77};
    int         eq [6] = '{512, 100, 1023, 156, 50, 77};
    int         got;
    got = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (out_valid) begin
        chk_cnt++;
        if (got >= 6)
          $display("FAIL b2b_extra: got extra output %0d expected none", out_data);
        else if (out_data !== 10'(eq[got]))
          $display("FAIL b2b_data%0d: got %0d expected %0d", got, out_data, eq[got]);
        else pass_cnt++;
        got++;
      end
      if (cyc < 6) begin
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d: got %b expected 1", cyc, in_ready);
        else pass_cnt++;
        set_beat(fq[cyc], p0q[cyc], p1q[cyc], 0, 0, cq[cyc]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk_cnt++;
    if (got !== 6) $display("FAIL b2b_count: got %0d outputs expected 6", got);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int idx;
    @(negedge clk);
    out_ready = 1'b0;
    set_beat(4'd0, 0, 0, 0, 0, 11);
    in_valid = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_after1: got %b expected 1", in_ready);
    else pass_cnt++;
    set_beat(4'd0, 0, 0, 0, 0, 22);
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_ready_after2: got %b expected 0", in_ready);
    else pass_cnt++;
    set_beat(4'd0, 0, 0, 0, 0, 33);
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 10'd11 || in_ready !== 1'b0)
      $display("FAIL bp_hold: got valid=%b data=%0d ready=%b expected valid=1 data=11 ready=0",
               out_valid, out_data, in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (out_data !== 10'd11) $display("FAIL bp_stable: got %0d expected 11", out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 10'd22)
      $display("FAIL bp_drain2: got valid=%b data=%0d expected valid=1 data=22", out_valid, out_data);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 10'd33)
      $display("FAIL bp_drain3: got valid=%b data=%0d expected valid=1 data=33", out_valid, out_data);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", out_valid);
    else pass_cnt++;
    // Refill with the consumer stalled, then reset mid-stream.
    out_ready = 1'b0;
    set_beat(4'd0, 0, 0, 0, 0, 44);
    in_valid = 1'b1;
    idx = 0;
    while (!out_valid && idx < 10) begin
      @(negedge clk);
      idx++;
    end
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL rst_prefill: got valid=%b expected 1", out_valid);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || out_data !== 10'd0)
      $display("FAIL rst_async: got valid=%b data=%0d expected valid=0 data=0", out_valid, out_data);
    else pass_cnt++;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_flushed: got %b expected 0", out_valid);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_beat(4'd0, 0, 0, 0, 0, 0);
    #23 rst = 1'b0;
    test_reset();
    test_filter();
    test_bypass();
    test_back_to_back();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
